jelly_rtos_scheduler: RTL and testbench
=======================================

# jelly_rtos_scheduler

Ready-queue and dispatch stage sitting directly downstream of the per-task control blocks. It collects the `req_rdq` requests from all tasks and admits them one per cycle via one-hot `rdy_tsk` pulses. From the tasks' READY levels and priorities it tracks the highest-priority ready task. It hands context-switch requests to the CPU/dispatcher over a valid/ready handshake.

## Interface
Parameters:
- `TASKS`, 16, number of task blocks attached.
- `TSKID_WIDTH`, 4, task id width; must satisfy 2^TSKID_WIDTH ≥ TASKS.
- `TSKPRI_WIDTH`, 4, priority width; numerically smaller value means higher priority.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `cke`  in  1  clock enable; when low, all state holds and `rdy_tsk` is 0.
- `req_rdq`  in  TASKS  per-task ready request (registered in each task block).
- `task_ready`  in  TASKS  per-task level, 1 while that task's state is READY.
- `tskpri`  in  TASKS*TSKPRI_WIDTH  packed priorities; task i occupies bits [i*TSKPRI_WIDTH +: TSKPRI_WIDTH].
- `rdy_tsk`  out  TASKS  one-hot admit pulse, combinational from `req_rdq` and the RR pointer.
- `busy`  out  1  1 while any `req_rdq` bit is set or a dispatch is pending.
- `top_valid`  out  1  registered; 1 when at least one task is ready.
- `top_tskid`  out  TSKID_WIDTH  registered highest-priority ready task.
- `dispatch_valid`  out  1  context-switch request.
- `dispatch_idle`  out  1  qualifies dispatch: 1 = switch to idle (no ready task).
- `dispatch_tskid`  out  TSKID_WIDTH  target task; don't-care when `dispatch_idle` = 1.
- `dispatch_ready`  in  1  dispatcher accepts the request.
- `run_valid`  out  1  a task is currently dispatched.
- `run_tskid`  out  TSKID_WIDTH  currently dispatched task.

## Operation
- **Admission:**
  - Round-robin pointer `rr_ptr` (TSKID_WIDTH bits).
  - Each cycle with `cke`, grant the first set `req_rdq` bit at index ≥ `rr_ptr`, wrapping modulo TASKS.
  - The grant drives `rdy_tsk[i]` = 1 for that cycle only.
  - On a grant, `rr_ptr` becomes i+1, wrapping to 0 at TASKS.
  - At most one grant per cycle. No grant when `req_rdq` == 0.
- **Selection:**
  - Combinational minimum search over tasks with `task_ready[i]`, on the key {`tskpri[i]`, i}. Equal priorities resolve to the lowest id.
  - The result is registered into `top_valid`/`top_tskid` every `cke` cycle.
- **Dispatch FSM, states S_IDLE and S_REQ:**
  - In S_IDLE, the FSM moves to S_REQ when the registered top differs from the running task. "Differs" means either:
    - `top_valid` ≠ `run_valid`, or
    - both are 1 and `top_tskid` ≠ `run_tskid`.
  - On entering S_REQ, latch `dispatch_tskid` ← `top_tskid` and `dispatch_idle` ← !`top_valid`.
  - In S_REQ, `dispatch_valid` = 1. `dispatch_tskid` and `dispatch_idle` stay stable until accepted, even if top changes.
  - When `dispatch_valid` && `dispatch_ready`:
    - `run_valid` ← !`dispatch_idle`.
    - `run_tskid` ← `dispatch_tskid`.
    - Return to S_IDLE.
    - A still-differing top re-enters S_REQ on the following cycle.
- **Out-of-range ids:** Task ids ≥ TASKS never appear on any output.

## Timing
- **Reset values:**
  - `rr_ptr` = 0, state = S_IDLE.
  - `top_valid`, `dispatch_valid`, `dispatch_idle` and `run_valid` = 0.
  - `top_tskid`, `dispatch_tskid` and `run_tskid` = 0.
- **Reset mid-operation:** Reset mid-handshake drops `dispatch_valid` next cycle, with no acceptance.
- **Admission latency:** 0 cycles. `rdy_tsk` is valid in the same cycle that `req_rdq` is high. The task block leaves REQRDY at the next edge, so `req_rdq` falls one cycle later.
- **Selection latency:** `task_ready`/`tskpri` change at edge N → `top_*` updates at edge N+1.
- **Dispatch latency:** S_REQ is entered at edge N+2, so `dispatch_valid` is high after edge N+2. The same-cycle `dispatch_ready` completes the handshake at edge N+3.
- **`busy`:** Combinational, (|`req_rdq`) | (state == S_REQ).
- **Clock enable:** `cke` low freezes the FSM, `rr_ptr` and the registers, and forces `rdy_tsk` to 0. `dispatch_valid` holds its value. A handshake counts only when `cke` = 1.

## Test plan
- **Reset state:** reset for 2 cycles → all outputs 0; `busy` = 0.
- **Round-robin admission:** `req_rdq` = 0x0005 held, `rr_ptr` = 0 → `rdy_tsk` 0x0001, then 0x0004, then 0x0001. Each pulse lasts one cycle.
- **Priority selection:**
  - Setup: `task_ready` = 0x0006, `tskpri[1]` = 3, `tskpri[2]` = 3.
  - `top_tskid` = 1 one cycle later.
  - After setting `tskpri[2]` = 2 → `top_tskid` = 2 on the next cycle.
- **Dispatch with backpressure:**
  - Task 5 becomes ready, `dispatch_ready` = 0 for 4 cycles.
  - `dispatch_valid` = 1 with `dispatch_tskid` = 5 held stable throughout.
  - Raising `dispatch_ready` → `run_tskid` = 5, `run_valid` = 1 next edge.
- **Top change during pending dispatch:**
  - Pending dispatch to 5; task 3 (higher priority) becomes ready.
  - The first accept yields `run_tskid` = 5.
  - A new request with `dispatch_tskid` = 3 follows one cycle after.
- **Idle dispatch:** `task_ready` → 0 while task 5 runs → `dispatch_valid` = 1, `dispatch_idle` = 1; after accept, `run_valid` = 0.

Source files
------------

// File: rtl/jelly_rtos_scheduler.sv
// jelly_rtos_scheduler: ready-queue admission, highest-priority selection and dispatch handshake
module jelly_rtos_scheduler #(
  parameter int TASKS        = 16,
  parameter int TSKID_WIDTH  = 4,
  parameter int TSKPRI_WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cke,
  input  logic [TASKS-1:0]              req_rdq,
  input  logic [TASKS-1:0]              task_ready,
  input  logic [TASKS*TSKPRI_WIDTH-1:0] tskpri,
  output logic [TASKS-1:0]              rdy_tsk,
  output logic                          busy,
  output logic                          top_valid,
  output logic [TSKID_WIDTH-1:0]        top_tskid,
  output logic                          dispatch_valid,
  output logic                          dispatch_idle,
  output logic [TSKID_WIDTH-1:0]        dispatch_tskid,
  input  logic                          dispatch_ready,
  output logic                          run_valid,
  output logic [TSKID_WIDTH-1:0]        run_tskid
);
  typedef enum logic {S_IDLE, S_REQ} state_t;
  state_t state, state_next;
  logic [TSKID_WIDTH-1:0]  rr_ptr, gnt_id, sel_id;
  logic [TASKS-1:0]        grant, req_hi;
  logic                    found, sel_v, differ;
  logic [TSKPRI_WIDTH-1:0] sel_pri;

  // round-robin grant: first request at or above the pointer, else wrap to the lowest request
  always_comb begin
    req_hi = '0;
    grant  = '0;
    gnt_id = '0;
    found  = 1'b0;
    for (int i = 0; i < TASKS; i++) req_hi[i] = req_rdq[i] && (i >= int'(rr_ptr));
    for (int i = 0; i < TASKS; i++)
      if (!found && req_hi[i]) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        gnt_id   = TSKID_WIDTH'(i);
      end
    for (int i = 0; i < TASKS; i++)
      if (!found && req_rdq[i]) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        gnt_id   = TSKID_WIDTH'(i);
      end
  end

  assign rdy_tsk = cke ? grant : '0;

  // minimum search on {priority, id}; strict compare in ascending id order keeps the lowest id on ties
  always_comb begin
    sel_v   = 1'b0;
    sel_id  = '0;
    sel_pri = '0;
    for (int i = 0; i < TASKS; i++)
      if (task_ready[i] && (!sel_v || tskpri[i*TSKPRI_WIDTH +: TSKPRI_WIDTH] < sel_pri)) begin
        sel_v   = 1'b1;
        sel_id  = TSKID_WIDTH'(i);
        sel_pri = tskpri[i*TSKPRI_WIDTH +: TSKPRI_WIDTH];
      end
  end

  // dispatch next state: request when the registered top disagrees with the running task
  always_comb begin
    differ     = (top_valid != run_valid) || (top_valid && run_valid && top_tskid != run_tskid);
    state_next = state;
    if (cke && state == S_IDLE && differ) state_next = S_REQ;
    if (cke && state == S_REQ && dispatch_ready) state_next = S_IDLE;
  end

  assign dispatch_valid = state == S_REQ;
  assign busy           = (|req_rdq) || state == S_REQ;

  // pointer, top register, FSM state, latched request and running task
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      rr_ptr         <= '0;
      top_valid      <= 1'b0;
      top_tskid      <= '0;
      dispatch_idle  <= 1'b0;
      dispatch_tskid <= '0;
      run_valid      <= 1'b0;
      run_tskid      <= '0;
    end else if (cke) begin
      state     <= state_next;
      top_valid <= sel_v;
      top_tskid <= sel_id;
      if (found) rr_ptr <= (int'(gnt_id) == TASKS-1) ? '0 : gnt_id + 1'b1;
      if (state == S_IDLE && differ) begin
        dispatch_tskid <= top_tskid;
        dispatch_idle  <= !top_valid;
      end
      if (state == S_REQ && dispatch_ready) begin
        run_valid <= !dispatch_idle;
        run_tskid <= dispatch_tskid;
      end
    end
  end
endmodule

// File: tb/tb_jelly_rtos_scheduler.sv
// tb_jelly_rtos_scheduler: behavioural model compare every cycle plus directed literal checks
module tb_jelly_rtos_scheduler;
  localparam int T = 16;
  localparam int IW = 4;
  localparam int PW = 4;

  logic clk = 1'b0;
  logic reset, cke, dispatch_ready;
  logic [T-1:0] req_rdq, task_ready, rdy_tsk;
  logic [T*PW-1:0] tskpri;
  logic busy, top_valid, dispatch_valid, dispatch_idle, run_valid;
  logic [IW-1:0] top_tskid, dispatch_tskid, run_tskid;

  int n_cmp = 0;
  int n_err = 0;

  jelly_rtos_scheduler #(.TASKS(T), .TSKID_WIDTH(IW), .TSKPRI_WIDTH(PW)) dut (
    .clk(clk), .reset(reset), .cke(cke), .req_rdq(req_rdq), .task_ready(task_ready),
    .tskpri(tskpri), .rdy_tsk(rdy_tsk), .busy(busy), .top_valid(top_valid),
    .top_tskid(top_tskid), .dispatch_valid(dispatch_valid), .dispatch_idle(dispatch_idle),
    .dispatch_tskid(dispatch_tskid), .dispatch_ready(dispatch_ready),
    .run_valid(run_valid), .run_tskid(run_tskid)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int grant_of(logic [T-1:0] req, int rr);
    for (int k = 0; k < T; k++)
      if (req[(rr + k) % T]) return (rr + k) % T;
    return -1;
  endfunction

  function automatic int best_of(logic [T-1:0] rdy, logic [T*PW-1:0] pri);
    for (int p = 0; p < (1 << PW); p++)
      for (int i = 0; i < T; i++)
        if (rdy[i] && int'(pri[i*PW +: PW]) == p) return i;
    return -1;
  endfunction

  int m_rr, m_tid, m_tgt, m_rid;
  bit m_tv, m_pend, m_idle, m_rv, chk_en;

  // reference model advances on each edge, then the DUT is compared 1ns later
  always @(posedge clk) begin
    int g, b;
    bit dif;
    g = grant_of(req_rdq, m_rr);
    if (reset) begin
      m_rr = 0; m_tv = 0; m_tid = 0; m_pend = 0; m_idle = 0; m_tgt = 0; m_rv = 0; m_rid = 0;
      chk_en = 1;
    end else if (cke) begin
      dif = (m_tv != m_rv) || (m_tv && m_rv && m_tid != m_rid);
      if (m_pend && dispatch_ready) begin
        m_rv = !m_idle; m_rid = m_tgt; m_pend = 0;
      end else if (!m_pend && dif) begin
        m_pend = 1; m_tgt = m_tid; m_idle = !m_tv;
      end
      if (g >= 0) m_rr = (g + 1) % T;
      b = best_of(task_ready, tskpri);
      m_tv = b >= 0;
      m_tid = b < 0 ? 0 : b;
    end
    #1;
    if (chk_en) begin
      g = grant_of(req_rdq, m_rr);
      chk("rdy_tsk", 32'(rdy_tsk), (cke && g >= 0) ? 32'(1) << g : 32'(0));
      chk("busy", 32'(busy), 32'((req_rdq != 0) || m_pend));
      chk("top_valid", 32'(top_valid), 32'(m_tv));
      if (m_tv) chk("top_tskid", 32'(top_tskid), 32'(m_tid));
      chk("dispatch_valid", 32'(dispatch_valid), 32'(m_pend));
      if (m_pend) chk("dispatch_idle", 32'(dispatch_idle), 32'(m_idle));
      if (m_pend && !m_idle) chk("dispatch_tskid", 32'(dispatch_tskid), 32'(m_tgt));
      chk("run_valid", 32'(run_valid), 32'(m_rv));
      if (m_rv) chk("run_tskid", 32'(run_tskid), 32'(m_rid));
    end
  end

  task automatic setpri(int i, int p);
    tskpri[i*PW +: PW] = PW'(p);
  endtask

  initial begin
    reset = 1; cke = 1; req_rdq = '0; task_ready = '0; tskpri = '1; dispatch_ready = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst top_valid", 32'(top_valid), 0);
    chk("rst top_tskid", 32'(top_tskid), 0);
    chk("rst dispatch_valid", 32'(dispatch_valid), 0);
    chk("rst dispatch_idle", 32'(dispatch_idle), 0);
    chk("rst dispatch_tskid", 32'(dispatch_tskid), 0);
    chk("rst run_valid", 32'(run_valid), 0);
    chk("rst run_tskid", 32'(run_tskid), 0);
    chk("rst busy", 32'(busy), 0);
    reset = 0;
    // round robin over requests 0 and 2
    @(negedge clk); req_rdq = 16'h0005; #1 chk("rr first", 32'(rdy_tsk), 32'h1);
    @(negedge clk); #1 chk("rr second", 32'(rdy_tsk), 32'h4);
    @(negedge clk); #1 chk("rr wrap", 32'(rdy_tsk), 32'h1);
    req_rdq = '0;
    // priority tie then reprioritise
    @(negedge clk); task_ready = 16'h0006; setpri(1, 3); setpri(2, 3);
    @(negedge clk); #1 chk("sel tie valid", 32'(top_valid), 1); chk("sel tie id", 32'(top_tskid), 1);
    setpri(2, 2);
    @(negedge clk); #1 chk("sel repri id", 32'(top_tskid), 2);
    task_ready = '0; dispatch_ready = 1;
    repeat (6) @(negedge clk);
    dispatch_ready = 0;
    // dispatch held under backpressure
    task_ready = 16'h0020; setpri(5, 4);
    repeat (2) @(negedge clk);
    repeat (4) begin
      #1 chk("bp valid", 32'(dispatch_valid), 1); chk("bp tskid", 32'(dispatch_tskid), 5);
      @(negedge clk);
    end
    dispatch_ready = 1;
    @(negedge clk); #1 chk("bp run_valid", 32'(run_valid), 1); chk("bp run_tskid", 32'(run_tskid), 5);
    dispatch_ready = 0;
    // switch to idle
    task_ready = '0;
    repeat (2) @(negedge clk);
    #1 chk("idle valid", 32'(dispatch_valid), 1); chk("idle flag", 32'(dispatch_idle), 1);
    dispatch_ready = 1;
    @(negedge clk); #1 chk("idle run_valid", 32'(run_valid), 0);
    dispatch_ready = 0;
    // top changes while a dispatch is pending
    task_ready = 16'h0020;
    repeat (2) @(negedge clk);
    #1 chk("chg pend tskid", 32'(dispatch_tskid), 5);
    task_ready = 16'h0028; setpri(3, 1);
    repeat (2) @(negedge clk);
    #1 chk("chg held tskid", 32'(dispatch_tskid), 5);
    dispatch_ready = 1;
    @(negedge clk); #1 chk("chg run_tskid", 32'(run_tskid), 5); chk("chg gap", 32'(dispatch_valid), 0);
    dispatch_ready = 0;
    @(negedge clk); #1 chk("chg revalid", 32'(dispatch_valid), 1); chk("chg new tskid", 32'(dispatch_tskid), 3);
    dispatch_ready = 1;
    @(negedge clk); dispatch_ready = 0;
    // clock enable low blocks admission
    cke = 0; req_rdq = 16'h0003;
    #1 chk("cke rdy", 32'(rdy_tsk), 0); chk("cke busy", 32'(busy), 1);
    @(negedge clk); #1 chk("cke rdy hold", 32'(rdy_tsk), 0);
    cke = 1;
    @(negedge clk); req_rdq = '0;
    // reset in the middle of a handshake
    task_ready = 16'h0080; setpri(7, 0);
    repeat (2) @(negedge clk);
    #1 chk("mid pend", 32'(dispatch_valid), 1); chk("mid tskid", 32'(dispatch_tskid), 7);
    reset = 1;
    @(negedge clk); #1 chk("mid drop", 32'(dispatch_valid), 0); chk("mid run", 32'(run_valid), 0);
    reset = 0;
    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
